multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_pkg.sv | 37 +++
 rtl/mc_decoder.sv | 77 +++++++
 rtl/multicycle_sequencer.sv | 170 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
//   state_t      : FSM state encoding, also visible on the State debug output
//   OP_*         : supported major opcodes
//   IMM_*        : ImmSrc immediate-format encodings
//   WB_*         : RUDataWrSrc writeback-source encodings
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction-class and datapath-control decode.
//   opcode, funct3, funct7 : instruction-register fields
//   legal                  : opcode is one of the supported classes
//   is_load/is_store       : memory-access classes
//   is_branch/is_jump      : conditional branch / JAL or JALR
//   imm_src, alu_op        : immediate format and ALU operation for EXEC
//   alu_a_src, alu_b_src   : ALU operand selects (A: 0=rs1 1=PC, B: 0=rs2 1=imm)
module mc_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic [2:0] imm_src,
  output logic [3:0] alu_op,
  output logic       alu_a_src,
  output logic       alu_b_src
);

  // Only funct7[5] distinguishes ALU operations (add/sub, srl/sra).
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    legal     = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    imm_src   = IMM_I;
    alu_op    = 4'b0000;
    alu_a_src = 1'b0;
    alu_b_src = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        alu_b_src = 1'b0;
        alu_op    = {funct7[5], funct3};
      end
      OP_IALU:  alu_op = {1'b0, funct3};
      OP_LOAD:  is_load = 1'b1;
      OP_STORE: begin
        is_store = 1'b1;
        imm_src  = IMM_S;
      end
      // Branch target PC+imm is computed by the ALU; the compare is
      // done by the separate branch unit.
      OP_BRANCH: begin
        is_branch = 1'b1;
        imm_src   = IMM_B;
        alu_a_src = 1'b1;
      end
      OP_JAL: begin
        is_jump   = 1'b1;
        imm_src   = IMM_J;
        alu_a_src = 1'b1;
      end
      OP_JALR: is_jump = 1'b1;
      // LUI passes the U immediate through an add; the datapath is
      // expected to present zero on operand A for this opcode.
      OP_LUI:  imm_src = IMM_U;
      OP_AUIPC: begin
        imm_src   = IMM_U;
        alu_a_src = 1'b1;
      end
      default: begin
        legal     = 1'b0;
        alu_b_src = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, rst (async, active high)
//   OpCode/Funct3/Funct7 : IR fields, stable after the fetch completes
//   BrTaken              : branch-unit compare result
//   MemReady / MemReq    : memory handshake. MemReq is held high for the
//                          whole request; a cycle with MemReq=1 and
//                          MemReady=1 completes it. MemReady is ignored
//                          while MemReq=0.
//   MemAddrSrc, IRWr, PCWr, PCSrc, ImmSrc, ALUASrc, ALUBSrc, ALUOp,
//   DMWr, DMCtrl, RUDataWrSrc, RUWr, BrOp : datapath controls
//   Fault : sticky illegal-opcode / memory-timeout flag
//   State : current FSM state (debug)
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OpCode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       BrTaken,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemAddrSrc,
  output logic       IRWr,
  output logic       PCWr,
  output logic       PCSrc,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOp,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [1:0] RUDataWrSrc,
  output logic       RUWr,
  output logic       BrOp,
  output logic       Fault,
  output logic [2:0] State
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  // The last permitted wait cycle: a miss here is the MEM_TIMEOUT-th wait.
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          waiting;
  logic          limit_hit;

  logic       legal, is_load, is_store, is_branch, is_jump;
  logic [2:0] dec_imm_src;
  logic [3:0] dec_alu_op;
  logic       dec_a_src, dec_b_src;

  mc_decoder u_dec (
    .opcode    (OpCode),
    .funct3    (Funct3),
    .funct7    (Funct7),
    .legal     (legal),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .imm_src   (dec_imm_src),
    .alu_op    (dec_alu_op),
    .alu_a_src (dec_a_src),
    .alu_b_src (dec_b_src)
  );

  assign waiting   = ((state == ST_FETCH) || (state == ST_MEM)) && !MemReady;
  assign limit_hit = (wait_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Any state change clears the counter, so FETCH and MEM start at 0.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    MemReq      = 1'b0;
    MemAddrSrc  = 1'b0;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    PCSrc       = 1'b0;
    ImmSrc      = IMM_I;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    ALUOp       = 4'b0000;
    DMWr        = 1'b0;
    DMCtrl      = 3'b000;
    RUDataWrSrc = WB_ALU;
    RUWr        = 1'b0;
    BrOp        = 1'b0;
    // Outputs are held at zero for the whole reset window.
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          MemReq = 1'b1;
          // MemReady wins over a simultaneous timeout.
          if (MemReady) begin
            IRWr      = 1'b1;
            state_nxt = ST_DECODE;
          end else if (limit_hit) begin
            state_nxt = ST_FAULT;
          end
        end
        ST_DECODE: state_nxt = legal ? ST_EXEC : ST_FAULT;
        ST_EXEC: begin
          ImmSrc  = dec_imm_src;
          ALUASrc = dec_a_src;
          ALUBSrc = dec_b_src;
          ALUOp   = dec_alu_op;
          if (is_load || is_store) begin
            DMCtrl    = Funct3;
            state_nxt = ST_MEM;
          end else if (is_branch) begin
            BrOp      = 1'b1;
            PCWr      = 1'b1;
            PCSrc     = BrTaken;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
        ST_MEM: begin
          MemReq     = 1'b1;
          MemAddrSrc = 1'b1;
          DMWr       = is_store;
          DMCtrl     = Funct3;
          if (MemReady) begin
            if (is_store) begin
              PCWr      = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_WB;
            end
          end else if (limit_hit) begin
            state_nxt = ST_FAULT;
          end
        end
        ST_WB: begin
          RUWr        = 1'b1;
          PCWr        = 1'b1;
          PCSrc       = is_jump;
          RUDataWrSrc = is_load ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
          DMCtrl      = is_load ? Funct3 : 3'b000;
          state_nxt   = ST_FETCH;
        end
        ST_FAULT: state_nxt = ST_FAULT;
        // Unused encodings are treated as a fault.
        default:  state_nxt = ST_FAULT;
      endcase
    end
  end

  assign Fault = (state == ST_FAULT);
  assign State = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int MEM_TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] OpCode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       BrTaken, MemReady;
  logic       MemReq, MemAddrSrc, IRWr, PCWr, PCSrc, ALUASrc, ALUBSrc;
  logic       DMWr, RUWr, BrOp, Fault;
  logic [2:0] ImmSrc, DMCtrl, State;
  logic [3:0] ALUOp;
  logic [1:0] RUDataWrSrc;

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .BrTaken(BrTaken), .MemReady(MemReady), .MemReq(MemReq),
    .MemAddrSrc(MemAddrSrc), .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc),
    .ImmSrc(ImmSrc), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .RUDataWrSrc(RUDataWrSrc), .RUWr(RUWr),
    .BrOp(BrOp), .Fault(Fault), .State(State)
  );

  logic [25:0] all_out;
  assign all_out = {MemReq, MemAddrSrc, IRWr, PCWr, PCSrc, ImmSrc, ALUASrc,
                    ALUBSrc, ALUOp, DMWr, DMCtrl, RUDataWrSrc, RUWr, BrOp,
                    Fault, State};
  logic [4:0] we;
  assign we = {MemReq, IRWr, PCWr, DMWr, RUWr};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-instruction summary ----------------
  typedef struct packed {
    logic [3:0] irwr_n;
    logic [3:0] pcwr_n;
    logic       pcsrc;
    logic [3:0] ruwr_n;
    logic [1:0] wbsrc;
    logic [7:0] dmwr_n;
    logic [3:0] brop_n;
    logic [3:0] aluop;
    logic [2:0] imm;
    logic       asrc;
    logic       bsrc;
    logic [2:0] dmctrl;
    logic       fault;
  } summ_t;
  localparam int SW = $bits(summ_t);

  logic [SW-1:0] exp_q[$];
  logic [2:0]    act_trace[$];
  logic [2:0]    exp_trace[$];

  // ---------------- reference model ----------------
  // Instruction phases: fetch (df waits + 1), decode, exec, optional memory
  // access (dm waits + 1) for loads/stores, writeback for everything that
  // writes a register.
  function automatic summ_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic br, input int dm);
    summ_t m;
    bit ld, st, bra, jmp;
    ld  = (op == 7'b0000011);
    st  = (op == 7'b0100011);
    bra = (op == 7'b1100011);
    jmp = (op == 7'b1101111) || (op == 7'b1100111);
    m = '0;
    m.irwr_n = 4'd1;
    m.pcwr_n = 4'd1;
    m.pcsrc  = bra ? br : jmp;
    m.ruwr_n = (st || bra) ? 4'd0 : 4'd1;
    m.wbsrc  = ld ? 2'b01 : (jmp ? 2'b10 : 2'b00);
    m.dmwr_n = st ? 8'(dm + 1) : 8'd0;
    m.brop_n = bra ? 4'd1 : 4'd0;
    if (op == 7'b0110011)      m.aluop = {f7[5], f3};
    else if (op == 7'b0010011) m.aluop = {1'b0, f3};
    else                       m.aluop = 4'b0000;
    case (op)
      7'b0100011:             m.imm = 3'b001;
      7'b1100011:             m.imm = 3'b101;
      7'b1101111:             m.imm = 3'b110;
      7'b0110111, 7'b0010111: m.imm = 3'b010;
      default:                m.imm = 3'b000;
    endcase
    m.asrc   = bra || (op == 7'b1101111) || (op == 7'b0010111);
    m.bsrc   = (op != 7'b0110011);
    m.dmctrl = (ld || st) ? f3 : 3'b000;
    m.fault  = 1'b0;
    return m;
  endfunction

  task automatic expect_trace(input logic [6:0] op, input int df, input int dm);
    exp_trace.delete();
    repeat (df + 1) exp_trace.push_back(3'd0);
    exp_trace.push_back(3'd1);
    exp_trace.push_back(3'd2);
    if (op == 7'b0000011 || op == 7'b0100011) repeat (dm + 1) exp_trace.push_back(3'd3);
    if (op != 7'b0100011 && op != 7'b1100011) exp_trace.push_back(3'd4);
  endtask

  task automatic check_trace(input string name);
    int bad;
    int n;
    bad = -1;
    n = (act_trace.size() < exp_trace.size()) ? act_trace.size() : exp_trace.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && act_trace[i] !== exp_trace[i]) bad = i;
    if (bad < 0 && act_trace.size() != exp_trace.size()) bad = n;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: state trace length %0d differs from required length %0d (first diff at cycle %0d)",
               name, act_trace.size(), exp_trace.size(), bad);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one instruction from its first FETCH cycle to retirement (PCWr) or
  // Fault. The memory answers the fetch after df wait cycles and the data
  // access after dm wait cycles. Starts in the low clock phase.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic br, input int df, input int dm, output summ_t s);
    int wc, req, cyc, budget;
    bit done;
    OpCode = op; Funct3 = f3; Funct7 = f7; BrTaken = br;
    s = '0; wc = 0; req = 0; cyc = 0; done = 0;
    budget = df + dm + 12;
    act_trace.delete();
    while (!done) begin
      MemReady = MemReq && (wc == ((req == 0) ? df : dm));
      #1;
      cyc++;
      act_trace.push_back(State);
      if (IRWr) s.irwr_n = s.irwr_n + 4'd1;
      if (PCWr) begin s.pcwr_n = s.pcwr_n + 4'd1; s.pcsrc = PCSrc; end
      if (RUWr) begin s.ruwr_n = s.ruwr_n + 4'd1; s.wbsrc = RUDataWrSrc; end
      if (DMWr) s.dmwr_n = s.dmwr_n + 8'd1;
      if (BrOp) s.brop_n = s.brop_n + 4'd1;
      if (cyc == df + 3) begin
        s.aluop = ALUOp; s.imm = ImmSrc; s.asrc = ALUASrc; s.bsrc = ALUBSrc;
      end
      if (MemReq) begin
        if (MemReady) begin req++; wc = 0; end
        else wc++;
      end
      if (PCWr || Fault || cyc >= budget) begin
        done = 1;
        s.dmctrl = DMCtrl;
        s.fault  = Fault;
        if (!PCWr && !Fault) check("cycle_budget_expired", 1, 0);
      end
      @(negedge clk);
    end
    MemReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    MemReady = 1'b0;
    #1;
    check("reset_all_outputs_zero", all_out, 26'd0);
    @(negedge clk);
    #1;
    check("reset_held_outputs_zero", all_out, 26'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       br;
    int         cycles;
    logic       pcsrc;
    logic [1:0] wbsrc;
    logic [3:0] ruwr;
    logic [3:0] aluop;
    logic [2:0] imm;
  } vec_t;
  vec_t vt[12];

  logic [6:0] legal_ops[9];

  // ---------------- main test ----------------
  initial begin
    summ_t s, m;
    logic [SW-1:0] exp_w;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic br;
    int df, dm;

    vt[0]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b1000, 3'b000};
    vt[1]  = '{7'b0110011, 3'b101, 7'b0000000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b0101, 3'b000};
    vt[2]  = '{7'b0010011, 3'b111, 7'b0000000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b0111, 3'b000};
    vt[3]  = '{7'b0010011, 3'b101, 7'b0100000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b0101, 3'b000};
    vt[4]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 5, 1'b0, 2'b01, 4'd1, 4'b0000, 3'b000};
    vt[5]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 4, 1'b0, 2'b00, 4'd0, 4'b0000, 3'b001};
    vt[6]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 3, 1'b1, 2'b00, 4'd0, 4'b0000, 3'b101};
    vt[7]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 3, 1'b0, 2'b00, 4'd0, 4'b0000, 3'b101};
    vt[8]  = '{7'b1101111, 3'b000, 7'b0000000, 1'b0, 4, 1'b1, 2'b10, 4'd1, 4'b0000, 3'b110};
    vt[9]  = '{7'b1100111, 3'b000, 7'b0000000, 1'b0, 4, 1'b1, 2'b10, 4'd1, 4'b0000, 3'b000};
    vt[10] = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b0000, 3'b010};
    vt[11] = '{7'b0010111, 3'b000, 7'b0000000, 1'b0, 4, 1'b0, 2'b00, 4'd1, 4'b0000, 3'b010};

    legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
    legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
    legal_ops[6] = 7'b1100111; legal_ops[7] = 7'b0110111; legal_ops[8] = 7'b0010111;

    rst = 1'b1; OpCode = '0; Funct3 = '0; Funct7 = '0; BrTaken = 1'b0; MemReady = 1'b0;
    #3;
    check("reset_initial_outputs_zero", all_out, 26'd0);
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    check("reset_ignores_memready", all_out, 26'd0);
    MemReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_state_fetch", State, 3'd0);
    check("post_reset_memreq", MemReq, 1'b1);

    // Table: MemReady tied high.
    for (int i = 0; i < 12; i++) begin
      run_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].br, 0, 0, s);
      check($sformatf("vec%0d_cycles", i), act_trace.size(), vt[i].cycles);
      check($sformatf("vec%0d_pcsrc", i), s.pcsrc, vt[i].pcsrc);
      check($sformatf("vec%0d_wbsrc", i), s.wbsrc, vt[i].wbsrc);
      check($sformatf("vec%0d_ruwr", i), s.ruwr_n, vt[i].ruwr);
      check($sformatf("vec%0d_aluop", i), s.aluop, vt[i].aluop);
      check($sformatf("vec%0d_immsrc", i), s.imm, vt[i].imm);
    end

    // add: states 0,1,2,4, single retirement pulses.
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, s);
    expect_trace(7'b0110011, 0, 0);
    check_trace("add_state_trace");
    check("add_pcwr_count", s.pcwr_n, 4'd1);
    check("add_ruwr_count", s.ruwr_n, 4'd1);
    check("add_last_state_wb", act_trace[act_trace.size() - 1], 3'd4);

    // lw with three MemReady-low cycles in MEM.
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 3, s);
    expect_trace(7'b0000011, 0, 3);
    check_trace("lw_wait_state_trace");
    check("lw_wbsrc", s.wbsrc, 2'b01);
    check("lw_dmctrl", s.dmctrl, 3'b010);

    // Illegal opcode: FAULT after DECODE, absorbing.
    OpCode = 7'b1111111;
    MemReady = 1'b1;
    #1;
    check("illegal_fetch_irwr", IRWr, 1'b1);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    check("illegal_decode_state", State, 3'd1);
    @(negedge clk);
    #1;
    check("illegal_fault_state", State, 3'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      MemReady = i[0];
      #1;
      check("fault_hold", {Fault, State, we}, {1'b1, 3'd7, 5'b00000});
    end
    do_reset();
    check("fault_cleared_by_reset", {Fault, State}, 4'b0000);

    // FETCH timeout: 16 waiting cycles.
    repeat (15) @(negedge clk);
    #1;
    check("fetch_wait16_still_fetch", State, 3'd0);
    @(negedge clk);
    #1;
    check("fetch_timeout_fault", {Fault, State}, {1'b1, 3'd7});
    do_reset();
    // Same, but MemReady arrives on the 16th cycle.
    OpCode = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0000000;
    repeat (15) @(negedge clk);
    MemReady = 1'b1;
    #1;
    check("fetch_ready_at_limit_irwr", IRWr, 1'b1);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    check("fetch_ready_at_limit_decode", State, 3'd1);
    do_reset();

    // MEM timeout for a load.
    OpCode = 7'b0000011; Funct3 = 3'b010;
    MemReady = 1'b1;
    @(negedge clk);
    MemReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mem_entry_state", State, 3'd3);
    repeat (15) @(negedge clk);
    #1;
    check("mem_wait16_still_mem", State, 3'd3);
    @(negedge clk);
    #1;
    check("mem_timeout_fault", {Fault, State}, {1'b1, 3'd7});
    do_reset();

    // Reset during MEM of a store.
    OpCode = 7'b0100011; Funct3 = 3'b010;
    MemReady = 1'b1;
    @(negedge clk);
    MemReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sw_mem_dmwr", {State, DMWr}, {3'd3, 1'b1});
    #1;
    rst = 1'b1;
    #1;
    check("sw_reset_drops_enables", {State, we}, {3'd0, 5'b00000});
    @(negedge clk);
    #1;
    check("sw_reset_held_no_pcwr", {PCWr, RUWr, DMWr}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("sw_reset_restart_fetch", {State, MemReq}, {3'd0, 1'b1});
    run_instr(7'b0100011, 3'b001, 7'b0000000, 1'b0, 1, 2, s);
    m = model(7'b0100011, 3'b001, 7'b0000000, 1'b0, 2);
    check("sw_after_reset_summary", s, m);

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      br = 1'($urandom_range(0, 1));
      df = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 3);
      dm = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 3);
      exp_q.push_back(model(op, f3, f7, br, dm));
      expect_trace(op, df, dm);
      run_instr(op, f3, f7, br, df, dm, s);
      exp_w = exp_q.pop_front();
      check($sformatf("rand%0d_op%b_summary", n, op), s, exp_w);
      check_trace($sformatf("rand%0d_op%b_trace", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
